// File: rtl/ws2812_frame_reader.sv
// WS2812 frame reader: fetches NUM_LEDS*3 colour bytes from a 1-cycle-latency bram port
// and drives them MSB-first as a one-wire waveform, followed by a latch period and a done pulse.
module ws2812_frame_reader #(
  parameter int NUM_LEDS      = 60,
  parameter int DATA_WIDTH    = 8,
  parameter int ADDRESS_WIDTH = 7,
  parameter int BASE_ADDR     = 0,
  parameter int BIT_CYCLES    = 20,
  parameter int T0H_CYCLES    = 6,
  parameter int T1H_CYCLES    = 13,
  parameter int LATCH_CYCLES  = 1000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  output logic                     busy,
  output logic                     done,
  output logic                     mem_ren,
  output logic [ADDRESS_WIDTH-1:0] mem_raddr,
  input  logic [DATA_WIDTH-1:0]    mem_rdata,
  output logic                     led_out
);

  localparam int NB = NUM_LEDS * 3;
  localparam int CW = $clog2(BIT_CYCLES);
  localparam int LW = $clog2(LATCH_CYCLES + 1);
  localparam int BW = $clog2(NB + 1);

  localparam logic [CW-1:0]            C_LAST = CW'(BIT_CYCLES - 1);
  localparam logic [CW-1:0]            C_T0H  = CW'(T0H_CYCLES);
  localparam logic [CW-1:0]            C_T1H  = CW'(T1H_CYCLES);
  localparam logic [LW-1:0]            L_LAST = LW'(LATCH_CYCLES - 1);
  localparam logic [BW-1:0]            B_LAST = BW'(NB - 1);
  localparam logic [ADDRESS_WIDTH-1:0] A_BASE = ADDRESS_WIDTH'(BASE_ADDR);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_LOAD  = 3'd2;
  localparam logic [2:0] S_SEND  = 3'd3;
  localparam logic [2:0] S_LATCH = 3'd4;

  logic [2:0]               r_state;
  logic                     r_busy;
  logic                     r_done;
  logic                     r_ren;
  logic                     r_pend;
  logic [ADDRESS_WIDTH-1:0] r_raddr;
  logic                     r_led;
  logic [BW-1:0]            r_byte;
  logic [2:0]               r_bit;
  logic [CW-1:0]            r_cyc;
  logic [LW-1:0]            r_lat;
  logic [7:0]               r_shift;
  logic [7:0]               r_pre;

  logic [CW-1:0] w_cyc_nxt;
  logic [BW-1:0] w_byte_nxt;
  logic [CW-1:0] w_thr;

  assign w_cyc_nxt  = r_cyc + 1'b1;
  assign w_byte_nxt = r_byte + 1'b1;
  assign w_thr      = r_shift[7] ? C_T1H : C_T0H;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_ren   <= 1'b0;
      r_pend  <= 1'b0;
      r_raddr <= A_BASE;
      r_led   <= 1'b0;
      r_byte  <= '0;
      r_bit   <= '0;
      r_cyc   <= '0;
      r_lat   <= '0;
    end else begin
      r_done <= 1'b0;
      r_ren  <= 1'b0;
      r_pend <= r_ren;
      case (r_state)
        S_IDLE: begin
          r_led <= 1'b0;
          // The done cycle itself is spent in IDLE; a start seen there is dropped.
          if (start && !r_done) begin
            r_state <= S_FETCH;
            r_busy  <= 1'b1;
            r_ren   <= 1'b1;
            r_raddr <= A_BASE;
          end
        end
        S_FETCH: r_state <= S_LOAD;
        S_LOAD: begin
          r_state <= S_SEND;
          r_byte  <= '0;
          r_bit   <= 3'd7;
          r_cyc   <= '0;
          r_led   <= 1'b1;
          r_ren   <= 1'b1;
          r_raddr <= r_raddr + 1'b1;
        end
        S_SEND: begin
          if (r_cyc == C_LAST) begin
            r_cyc <= '0;
            if (r_bit == 3'd0) begin
              if (r_byte == B_LAST) begin
                r_state <= S_LATCH;
                r_led   <= 1'b0;
                r_lat   <= '0;
              end else begin
                r_byte <= w_byte_nxt;
                r_bit  <= 3'd7;
                r_led  <= 1'b1;
                // Prefetch the byte after the one now starting, if any remains.
                if (w_byte_nxt != B_LAST) begin
                  r_ren   <= 1'b1;
                  r_raddr <= r_raddr + 1'b1;
                end
              end
            end else begin
              r_bit <= r_bit - 1'b1;
              r_led <= 1'b1;
            end
          end else begin
            r_cyc <= w_cyc_nxt;
            r_led <= (w_cyc_nxt < w_thr);
          end
        end
        S_LATCH: begin
          r_led <= 1'b0;
          if (r_lat == L_LAST) begin
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_lat <= r_lat + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (r_state == S_LOAD) begin
      r_shift <= mem_rdata;
    end else if (r_state == S_SEND && r_cyc == C_LAST) begin
      r_shift <= (r_bit == 3'd0) ? r_pre : {r_shift[6:0], 1'b0};
    end
    if (r_pend) begin
      r_pre <= mem_rdata;
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign mem_ren   = r_ren;
  assign mem_raddr = r_raddr;
  assign led_out   = r_led;

endmodule

// File: tb/tb_ws2812_frame_reader.sv
// Bench for ws2812_frame_reader: two instances (base 0 and base 126) checked cycle by cycle
// against a waveform model computed directly from the frame bytes.
module tb_ws2812_frame_reader;

  localparam int BITC = 10;
  localparam int T0H  = 3;
  localparam int T1H  = 7;
  localparam int LAT  = 50;
  localparam int NL   = 1;
  localparam int NB   = 3 * NL;
  localparam int FR   = 2 + NB * 8 * BITC + LAT;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start0 = 1'b0, start1 = 1'b0;
  logic       busy0, done0, ren0, led0;
  logic       busy1, done1, ren1, led1;
  logic [6:0] raddr0, raddr1;
  logic [7:0] rdata0, rdata1;
  logic [7:0] mem0 [128];
  logic [7:0] mem1 [128];
  logic [7:0] fb [NB];
  logic       sel = 1'b0;
  logic [10:0] obs;
  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  ws2812_frame_reader #(.NUM_LEDS(NL), .DATA_WIDTH(8), .ADDRESS_WIDTH(7), .BASE_ADDR(0),
    .BIT_CYCLES(BITC), .T0H_CYCLES(T0H), .T1H_CYCLES(T1H), .LATCH_CYCLES(LAT)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .busy(busy0), .done(done0), .mem_ren(ren0),
    .mem_raddr(raddr0), .mem_rdata(rdata0), .led_out(led0));

  ws2812_frame_reader #(.NUM_LEDS(NL), .DATA_WIDTH(8), .ADDRESS_WIDTH(7), .BASE_ADDR(126),
    .BIT_CYCLES(BITC), .T0H_CYCLES(T0H), .T1H_CYCLES(T1H), .LATCH_CYCLES(LAT)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .busy(busy1), .done(done1), .mem_ren(ren1),
    .mem_raddr(raddr1), .mem_rdata(rdata1), .led_out(led1));

  always @(posedge clk) begin
    if (ren0) rdata0 <= mem0[raddr0];
    if (ren1) rdata1 <= mem1[raddr1];
  end

  always_comb begin
    obs = '0;
    if (sel) obs = {led1, busy1, done1, ren1, ren1 ? raddr1 : 7'd0};
    else     obs = {led0, busy0, done0, ren0, ren0 ? raddr0 : 7'd0};
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // {led, busy, done, ren, addr} expected t cycles after the start-accepting edge
  function automatic logic [10:0] model(input int t, input int base);
    int bi, ph;
    logic led, ren;
    logic [6:0] a;
    led = 1'b0; ren = 1'b0; a = '0;
    if (t >= 2 && t < 2 + NB * 8 * BITC) begin
      bi  = (t - 2) / BITC;
      ph  = (t - 2) % BITC;
      led = (ph < (fb[bi / 8][7 - (bi % 8)] ? T1H : T0H));
    end
    for (int k = 0; k < NB; k++) begin
      if (t == ((k == 0) ? 0 : 2 + (k - 1) * 8 * BITC)) begin
        ren = 1'b1;
        a   = 7'((base + k) % 128);
      end
    end
    return {led, (t < FR), (t == FR), ren, a};
  endfunction

  task automatic set_start(input logic v);
    if (sel) start1 = v;
    else     start0 = v;
  endtask

  task automatic run_frame(input int fid, input bit pulse_mid, input int abort_t, input bit hold);
    int base;
    base = sel ? 126 : 0;
    for (int k = 0; k < NB; k++) fb[k] = sel ? mem1[(base + k) % 128] : mem0[(base + k) % 128];
    set_start(1'b1);
    @(posedge clk);
    for (int t = 0; t <= FR; t++) begin
      @(negedge clk);
      chk($sformatf("frame%0d t%0d", fid, t), 32'(obs), 32'(model(t, base)));
      if (!hold) set_start(1'b0);
      if (pulse_mid && t == 100) set_start(1'b1);
      if (t == abort_t) begin
        rst = 1'b1;
        @(negedge clk);
        chk($sformatf("frame%0d abort outs", fid), 32'(obs[10:7]), 32'd0);
        chk($sformatf("frame%0d abort addr", fid), 32'(sel ? raddr1 : raddr0), 32'(base));
        rst = 1'b0;
        return;
      end
    end
    @(negedge clk);
    chk($sformatf("frame%0d idle after done", fid), 32'(obs), 32'd0);
  endtask

  task automatic rand_bytes(input int base);
    for (int k = 0; k < NB; k++) begin
      if (sel) mem1[(base + k) % 128] = 8'($urandom);
      else     mem0[(base + k) % 128] = 8'($urandom);
    end
  endtask

  initial begin
    for (int i = 0; i < 128; i++) begin
      mem0[i] = 8'($urandom);
      mem1[i] = 8'($urandom);
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset outs0", 32'({led0, busy0, done0, ren0}), 32'd0);
    chk("reset outs1", 32'({led1, busy1, done1, ren1}), 32'd0);
    chk("reset addr0", 32'(raddr0), 32'd0);
    chk("reset addr1", 32'(raddr1), 32'd126);
    rst = 1'b0;
    @(negedge clk);

    sel = 1'b0;
    mem0[0] = 8'hA5; mem0[1] = 8'h00; mem0[2] = 8'hFF;
    run_frame(1, 1'b0, -1, 1'b0);
    for (int f = 2; f < 5; f++) begin
      rand_bytes(0);
      run_frame(f, 1'b0, -1, 1'b0);
    end
    rand_bytes(0);
    run_frame(5, 1'b1, -1, 1'b0);
    run_frame(6, 1'b0, 2 + 80 + 15, 1'b0);
    @(negedge clk);
    rand_bytes(0);
    run_frame(7, 1'b0, -1, 1'b0);
    run_frame(8, 1'b0, -1, 1'b1);
    rand_bytes(0);
    run_frame(9, 1'b0, -1, 1'b1);
    run_frame(10, 1'b0, -1, 1'b0);

    sel = 1'b1;
    mem1[126] = 8'h80; mem1[127] = 8'h01; mem1[0] = 8'h00;
    run_frame(11, 1'b0, -1, 1'b0);
    rand_bytes(126);
    run_frame(12, 1'b0, -1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
